// File: rtl/thread_out_buffer_pkg.sv
// thread_out_buffer_pkg
//   Shared defaults and FSM state encodings for the per-thread output
//   packet buffer (thread_out_buffer) and its storage RAM (thread_buf_ram).
//   No ports; imported by the RTL files of this block.
package thread_out_buffer_pkg;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int CTRL_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 8;

  // Buffer FSM encodings, kept as plain 2-bit constants so older code that
  // compares against raw values keeps working.
  localparam logic [1:0] ST_FILL      = 2'b00;
  localparam logic [1:0] ST_HELD      = 2'b01;
  localparam logic [1:0] ST_READ      = 2'b10;
  localparam logic [1:0] ST_DONE_WAIT = 2'b11;

endpackage

// File: rtl/thread_buf_ram.sv
// thread_buf_ram
//   Simple dual-port RAM holding one packet: DEPTH x (CTRL_WIDTH+DATA_WIDTH).
//   Write port and registered read port (1-cycle latency); no reset on the
//   array or read register so it maps onto block RAM.
// Ports:
//   clk      in   system clock
//   wr_en    in   write enable
//   wr_addr  in   write address
//   wr_data  in   write word {ctrl, data}
//   rd_en    in   read enable; rd_data updates on the next edge
//   rd_addr  in   read address
//   rd_data  out  registered read word {ctrl, data}
module thread_buf_ram
  import thread_out_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CTRL_WIDTH = CTRL_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [CTRL_WIDTH+DATA_WIDTH-1:0] wr_data,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [CTRL_WIDTH+DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [CTRL_WIDTH+DATA_WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/thread_out_buffer.sv
// thread_out_buffer
//   Per-thread output packet buffer in front of the output FIFO arbiter.
//   Captures one packet from the thread, reports completion with a
//   thread_done pulse, and on the arbiter's grant streams the packet out at
//   full rate with out_wr_early leading out_wr by one cycle.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   in_data/in_ctrl      thread write word
//   in_wr, in_last       write strobe, last-word qualifier
//   in_rdy               high while accepting writes (FILL)
//   thread_done          one-cycle pulse when a packet is committed
//   start_read           arbiter grant pulse (honoured only in HELD)
//   read_done            arbiter release pulse
//   out_data/out_ctrl    streamed word, valid with out_wr (zero otherwise)
//   out_wr               output write strobe
//   out_wr_early         out_wr of the next cycle
//   drop_err             one-cycle pulse per discarded write
module thread_out_buffer
  import thread_out_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CTRL_WIDTH = CTRL_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  input  logic                  in_last,
  output logic                  in_rdy,
  output logic                  thread_done,
  input  logic                  start_read,
  input  logic                  read_done,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  output logic                  out_wr_early,
  output logic                  drop_err
);

  localparam int W = DATA_WIDTH + CTRL_WIDTH;

  // Pointers carry one extra bit so a completely full buffer (DEPTH words)
  // is representable without wrapping.
  localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] PTR_ZERO = '0;

  logic [1:0]            state;
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   pkt_len;
  logic                  early_release;
  logic                  full;
  logic                  ram_we;
  logic                  issue;
  logic                  last_issue;
  logic [W-1:0]          rd_data;

  assign full       = (wr_ptr == DEPTH);
  assign ram_we     = (state == ST_FILL) && in_wr && !full;
  assign issue      = (state == ST_READ) && (rd_ptr < pkt_len);
  assign last_issue = issue && ((rd_ptr + PTR_ONE) == pkt_len);

  // out_wr_early is the RAM read issue itself; the RAM's one-cycle latency
  // makes the registered out_wr trail it by exactly one cycle. Both come
  // from async-reset state, so a reset silences the stream immediately.
  assign in_rdy       = (state == ST_FILL);
  assign out_wr_early = issue;

  // The RAM read register is not reset, so the data outputs are gated by
  // out_wr to read as zero whenever no word is being presented.
  assign out_data = out_wr ? rd_data[DATA_WIDTH-1:0] : '0;
  assign out_ctrl = out_wr ? rd_data[W-1:DATA_WIDTH] : '0;

  thread_buf_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .CTRL_WIDTH(CTRL_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .wr_en  (ram_we),
    .wr_addr(wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data({in_ctrl, in_data}),
    .rd_en  (issue),
    .rd_addr(rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data(rd_data)
  );

  // Buffer FSM. A read_done seen while still streaming is remembered in
  // early_release so the buffer returns straight to FILL after the last
  // issue instead of parking in DONE_WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_FILL;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      pkt_len       <= '0;
      early_release <= 1'b0;
      thread_done   <= 1'b0;
      drop_err      <= 1'b0;
      out_wr        <= 1'b0;
    end else begin
      thread_done <= 1'b0;
      out_wr      <= issue;
      drop_err    <= in_wr && ((state != ST_FILL) || full);

      case (state)
        ST_FILL: begin
          if (in_wr) begin
            if (!full) begin
              wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (in_last) begin
              pkt_len     <= full ? DEPTH : (wr_ptr + PTR_ONE);
              thread_done <= 1'b1;
              state       <= ST_HELD;
            end
          end
        end

        ST_HELD: begin
          if (start_read) begin
            rd_ptr <= '0;
            state  <= ST_READ;
          end
        end

        ST_READ: begin
          if (issue) begin
            rd_ptr <= rd_ptr + PTR_ONE;
          end
          if (read_done) begin
            early_release <= 1'b1;
          end
          if (!issue || last_issue) begin
            if (read_done || early_release) begin
              wr_ptr        <= PTR_ZERO;
              rd_ptr        <= PTR_ZERO;
              pkt_len       <= PTR_ZERO;
              early_release <= 1'b0;
              state         <= ST_FILL;
            end else begin
              state <= ST_DONE_WAIT;
            end
          end
        end

        ST_DONE_WAIT: begin
          if (read_done) begin
            wr_ptr  <= PTR_ZERO;
            rd_ptr  <= PTR_ZERO;
            pkt_len <= PTR_ZERO;
            state   <= ST_FILL;
          end
        end

        default: begin
          state <= ST_FILL;
        end
      endcase
    end
  end

endmodule
